// File: rtl/wb_data_stage.sv
// Write-back data stage: picks the destination-register value from the forwarding
// channels, extracted load data or the Rt operand, and holds it in a single
// valid/ready pipeline register between MEM and WB. Also counts consumed loads.
module wb_data_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned NFWD = 2,
    localparam int unsigned AW = $clog2(DW / 8)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5:0]          opcode,
    input  logic [AW-1:0]       addr_lo,
    input  logic [DW-1:0]       rt_data,
    input  logic [DW-1:0]       mem_data,
    input  logic [NFWD-1:0]     fwd_sel,
    input  logic [NFWD*DW-1:0]  fwd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic                out_is_load,
    output logic                out_misalign,
    output logic [31:0]         load_count
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;

    logic          valid_q;
    logic [DW-1:0] data_q;
    logic          is_load_q;
    logic          misalign_q;
    logic [31:0]   count_q;

    logic          capture;
    logic          consume;

    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   word_v;

    logic          ld_is_load;
    logic          ld_misalign;
    logic [DW-1:0] ld_val;

    logic          fwd_hit;
    logic [DW-1:0] fwd_val;

    logic [DW-1:0] sel_data;
    logic          sel_misalign;

    // Handshake: accept whenever the register is empty or being drained this cycle.
    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign consume  = valid_q && out_ready;

    // Lane extraction from the little-endian memory word.
    always_comb begin
        byte_v = mem_data[{addr_lo, 3'b000} +: 8];
        half_v = mem_data[{addr_lo[AW-1:1], 4'b0000} +: 16];
    end

    if (DW == 64) begin : g_word64
        assign word_v = mem_data[{addr_lo[AW-1:2], 5'b00000} +: 32];
    end else begin : g_word32
        assign word_v = mem_data[31:0];
    end

    // Load decode, extension and misalignment; misaligned loads yield zero.
    always_comb begin
        ld_is_load  = 1'b0;
        ld_misalign = 1'b0;
        ld_val      = '0;
        case (opcode)
            OP_LB: begin
                ld_is_load = 1'b1;
                ld_val     = DW'($signed(byte_v));
            end
            OP_LBU: begin
                ld_is_load = 1'b1;
                ld_val     = DW'(byte_v);
            end
            OP_LH: begin
                ld_is_load  = 1'b1;
                ld_misalign = addr_lo[0];
                ld_val      = DW'($signed(half_v));
            end
            OP_LHU: begin
                ld_is_load  = 1'b1;
                ld_misalign = addr_lo[0];
                ld_val      = DW'(half_v);
            end
            OP_LW: begin
                ld_is_load  = 1'b1;
                ld_misalign = (addr_lo[1:0] != 2'b00);
                ld_val      = DW'($signed(word_v));
            end
            default: begin
                ld_is_load = 1'b0;
            end
        endcase
        if (ld_misalign) begin
            ld_val = '0;
        end
    end

    // Forward mux: scan downward so the lowest-index requesting channel wins.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_val = '0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_sel[i]) begin
                fwd_hit = 1'b1;
                fwd_val = fwd_data[i*DW +: DW];
            end
        end
    end

    // Source priority: forward, then load data, then Rt.
    always_comb begin
        sel_data     = rt_data;
        sel_misalign = 1'b0;
        if (fwd_hit) begin
            sel_data = fwd_val;
        end else if (ld_is_load) begin
            sel_data     = ld_val;
            sel_misalign = ld_misalign;
        end
    end

    // Pipeline register and load counter; flush drops the entry and is never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            is_load_q  <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (capture) begin
                valid_q <= 1'b1;
            end else if (consume) begin
                valid_q <= 1'b0;
            end
            if (capture) begin
                data_q     <= sel_data;
                is_load_q  <= ld_is_load;
                misalign_q <= sel_misalign;
            end
            if (consume && is_load_q && !flush) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign out_valid    = valid_q;
    assign out_data     = data_q;
    assign out_is_load  = is_load_q;
    assign out_misalign = misalign_q;
    assign load_count   = count_q;

endmodule
